// File: rtl/seq_div_16bit_if.sv
// Handshake and operand/result bundle for the multi-cycle restoring divider.
// The control unit drives start and the operands; the divider drives the results.
interface seq_div_16bit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_div_16bit.sv
// Unsigned restoring divider: one trial subtraction (A + ~B + 1) per clock,
// WIDTH iterations per divide, with a start/busy/done handshake.
module seq_div_16bit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    seq_div_16bit_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   r_r;
    logic [WIDTH-1:0]   d_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   quotient_r;
    logic [WIDTH-1:0]   remainder_r;
    logic               busy_r;
    logic               done_r;
    logic               dbz_r;

    logic [WIDTH-1:0]   shift_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH-1:0]   q_next_s;
    logic [WIDTH-1:0]   r_next_s;

    // One restoring step: shift {R,Q} left, then try R - D as R + ~D + 1 at WIDTH+1 bits.
    always_comb begin
        shift_s  = {r_r[WIDTH-2:0], q_r[WIDTH-1]};
        trial_s  = {1'b0, shift_s} + {1'b0, ~d_r} + {{WIDTH{1'b0}}, 1'b1};
        q_next_s = {q_r[WIDTH-2:0], trial_s[WIDTH]};
        if (trial_s[WIDTH]) begin
            r_next_s = trial_s[WIDTH-1:0];
        end else begin
            r_next_s = shift_s;
        end
    end

    // Control FSM plus datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            q_r         <= {WIDTH{1'b0}};
            r_r         <= {WIDTH{1'b0}};
            d_r         <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        q_r   <= bus.dividend;
                        d_r   <= bus.divisor;
                        r_r   <= {WIDTH{1'b0}};
                        if (bus.divisor == {WIDTH{1'b0}}) begin
                            // Zero divisor skips iteration and reports immediately.
                            cnt_r       <= {CNT_W{1'b0}};
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            cnt_r   <= CNT_W'(WIDTH);
                            dbz_r   <= 1'b0;
                            busy_r  <= 1'b1;
                            state_r <= ST_RUN;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    q_r   <= q_next_s;
                    r_r   <= r_next_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        quotient_r  <= q_next_s;
                        remainder_r <= r_next_s;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;

endmodule
